ex_alu_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_core.sv | 61 ++++++
 rtl/ex_alu_unit.sv | 157 +++++++++++++++
 tb/tb_ex_alu_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: control word layout, opcode/funct3 encodings, FSM states.
// Optional build macro SERIAL_SHIFT_EN selects the bit-serial shifter in ex_alu_unit.
package alu_pkg;

  localparam logic [1:0] ALU_OP_ARITH  = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       funct7_5;
    logic [2:0] funct3;
  } alu_ctrl_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift(input alu_ctrl_t c);
    return (c.alu_op == ALU_OP_ARITH) && ((c.funct3 == F3_SLL) || (c.funct3 == F3_SR));
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU result and branch evaluation. With SERIAL_SHIFT_EN the shifter only
// handles amounts 0/1; longer shifts are iterated by ex_alu_unit.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_ctrl_t         ctrl_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [XLEN-1:0]   result_o,
  output logic              branch_taken_o
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;
  logic           eq;

`ifdef SERIAL_SHIFT_EN
  assign shamt = SHW'(b_i[0]);
`else
  assign shamt = b_i[SHW-1:0];
`endif

  assign lt_s = $signed(a_i) < $signed(b_i);
  assign lt_u = a_i < b_i;
  assign eq   = a_i == b_i;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    result_o       = '0;
    branch_taken_o = 1'b0;
    if (ctrl_i.alu_op == ALU_OP_ARITH) begin
      unique case (ctrl_i.funct3)
        F3_ADD:  result_o = ctrl_i.funct7_5 ? (a_i - b_i) : (a_i + b_i);
        F3_SLL:  result_o = a_i << shamt;
        F3_SLT:  result_o = XLEN'(lt_s);
        F3_SLTU: result_o = XLEN'(lt_u);
        F3_XOR:  result_o = a_i ^ b_i;
        F3_SR:   result_o = ctrl_i.funct7_5 ? XLEN'($signed(a_i) >>> shamt) : (a_i >> shamt);
        F3_OR:   result_o = a_i | b_i;
        F3_AND:  result_o = a_i & b_i;
        default: result_o = '0;
      endcase
    end else if (ctrl_i.alu_op == ALU_OP_BRANCH) begin
      unique case (ctrl_i.funct3)
        F3_BEQ:  branch_taken_o = eq;
        F3_BNE:  branch_taken_o = !eq;
        F3_BLT:  branch_taken_o = lt_s;
        F3_BGE:  branch_taken_o = !lt_s;
        F3_BLTU: branch_taken_o = lt_u;
        F3_BGEU: branch_taken_o = !lt_u;
        default: branch_taken_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU with valid/ready handshake, output register and optional bit-serial
// shifter (build macro SERIAL_SHIFT_EN); alu_core supplies the combinational datapath.
module ex_alu_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      alu_control,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic [4:0]      out_rd_addr
);

  localparam int SHW = $clog2(XLEN);

  alu_ctrl_t       ctrl;
  logic [XLEN-1:0] core_result;
  logic            core_bt;
  logic [SHW-1:0]  shamt;
  logic            accept;
  logic            start_serial;

  state_t          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] sh_val_q, sh_val_d;
  logic            sh_right_q, sh_right_d;
  logic            sh_arith_q, sh_arith_d;
  logic [4:0]      sh_rd_q, sh_rd_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            bt_q, bt_d;
  logic [4:0]      rd_q, rd_d;
  logic            rdy_q;

  function automatic logic [XLEN-1:0] shift_one(input logic [XLEN-1:0] v,
                                                input logic right, input logic arith);
    if (!right) return {v[XLEN-2:0], 1'b0};
    return {arith & v[XLEN-1], v[XLEN-1:1]};
  endfunction

  assign ctrl  = alu_ctrl_t'(alu_control);
  assign shamt = operand_b[SHW-1:0];

  alu_core #(.XLEN(XLEN)) u_core (
    .ctrl_i         (ctrl),
    .a_i            (operand_a),
    .b_i            (operand_b),
    .result_o       (core_result),
    .branch_taken_o (core_bt)
  );

`ifdef SERIAL_SHIFT_EN
  assign start_serial = is_shift(ctrl) && (shamt > SHW'(1));
`else
  assign start_serial = 1'b0;
`endif

  // rdy_q keeps in_ready low during reset and for the first cycle after release.
  assign in_ready = rdy_q && (state_q == ST_IDLE) && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_val_d    = sh_val_q;
    sh_right_d  = sh_right_q;
    sh_arith_d  = sh_arith_q;
    sh_rd_d     = sh_rd_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    bt_d        = bt_q;
    rd_d        = rd_q;

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
      cnt_d       = '0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (accept) begin
        if (start_serial) begin
          // The first bit moves on the accept edge, so amount-1 steps remain.
          state_d     = ST_SHIFT;
          cnt_d       = shamt - SHW'(1);
          sh_right_d  = ctrl.funct3[2];
          sh_arith_d  = ctrl.funct7_5;
          sh_val_d    = shift_one(operand_a, ctrl.funct3[2], ctrl.funct7_5);
          sh_rd_d     = rd_addr;
          out_valid_d = 1'b0;
        end else begin
          result_d    = core_result;
          bt_d        = core_bt;
          rd_d        = rd_addr;
          out_valid_d = 1'b1;
        end
      end else if (state_q == ST_SHIFT) begin
        if (cnt_q == SHW'(1)) begin
          result_d    = shift_one(sh_val_q, sh_right_q, sh_arith_q);
          bt_d        = 1'b0;
          rd_d        = sh_rd_q;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = '0;
        end else begin
          sh_val_d = shift_one(sh_val_q, sh_right_q, sh_arith_q);
          cnt_d    = cnt_q - SHW'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_val_q    <= '0;
      sh_right_q  <= 1'b0;
      sh_arith_q  <= 1'b0;
      sh_rd_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      bt_q        <= 1'b0;
      rd_q        <= '0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_val_q    <= sh_val_d;
      sh_right_q  <= sh_right_d;
      sh_arith_q  <= sh_arith_d;
      sh_rd_q     <= sh_rd_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      bt_q        <= bt_d;
      rd_q        <= rd_d;
      rdy_q       <= 1'b1;
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign branch_taken = bt_q;
  assign out_rd_addr  = rd_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit: directed vectors push expectations, a monitor pops and
// compares on every output transfer. Serial-shift expectations follow SERIAL_SHIFT_EN.
module tb_ex_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;
  logic [4:0]  out_rd_addr;

  typedef struct {
    logic [31:0] res;
    logic        bt;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

`ifdef SERIAL_SHIFT_EN
  localparam int SRA4_LAT = 4;
`else
  localparam int SRA4_LAT = 1;
`endif

  ex_alu_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_control  (alu_control),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .rd_addr      (rd_addr),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .out_rd_addr  (out_rd_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got rd %0d result %h expected none", out_rd_addr, result);
      end else begin
        e = sb.pop_front();
        check("sb_result", result, e.res);
        check("sb_branch", 32'(branch_taken), 32'(e.bt));
        check("sb_rd", 32'(out_rd_addr), 32'(e.rd));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] er, input logic eb);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: in_ready got 0 expected 1 for rd %0d", rd);
      return;
    end
    alu_control = c;
    operand_a   = a;
    operand_b   = b;
    rd_addr     = rd;
    in_valid    = 1'b1;
    sb.push_back('{er, eb, rd});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    int rdy_seen;
    rst_n = 1'b1; in_valid = 1'b0; alu_control = '0; operand_a = '0; operand_b = '0;
    rd_addr = '0; flush = 1'b0; out_ready = 1'b1;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result", result, 0);
    check("rst_rd", 32'(out_rd_addr), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Sub result held stable under backpressure
    @(posedge clk); #1 out_ready = 1'b0;
    issue(6'b00_1_000, 32'd5, 32'd3, 5'd7, 32'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_result", result, 32'd2);
      check("hold_rd", 32'(out_rd_addr), 32'd7);
      check("hold_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;

    // Arithmetic vectors
    issue(6'b00_0_000, 32'd5,         32'd3,         5'd1,  32'd8,         1'b0);
    issue(6'b00_0_000, 32'hFFFF_FFFF, 32'd1,         5'd2,  32'd0,         1'b0);
    issue(6'b00_1_000, 32'd0,         32'd1,         5'd3,  32'hFFFF_FFFF, 1'b0);
    issue(6'b00_0_001, 32'd3,         32'h21,        5'd4,  32'd6,         1'b0);
    issue(6'b00_0_010, 32'hFFFF_FFFF, 32'd1,         5'd5,  32'd1,         1'b0);
    issue(6'b00_0_011, 32'hFFFF_FFFF, 32'd1,         5'd6,  32'd0,         1'b0);
    issue(6'b00_0_100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7,  32'h0FF0_0FF0, 1'b0);
    issue(6'b00_0_101, 32'h8000_0000, 32'd4,         5'd8,  32'h0800_0000, 1'b0);
    issue(6'b00_0_110, 32'h0000_F000, 32'h0000_0F0F, 5'd9,  32'h0000_FF0F, 1'b0);
    issue(6'b00_0_111, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd10, 32'hF000_F000, 1'b0);
    issue(6'b00_0_001, 32'h0000_1234, 32'd0,         5'd11, 32'h0000_1234, 1'b0);
    issue(6'b00_0_001, 32'd1,         32'd31,        5'd12, 32'h8000_0000, 1'b0);

    // Branch and reserved alu_op vectors
    issue(6'b01_0_100, 32'hFFFF_FFFF, 32'd1, 5'd13, 32'd0, 1'b1);
    issue(6'b01_0_110, 32'hFFFF_FFFF, 32'd1, 5'd14, 32'd0, 1'b0);
    issue(6'b01_0_000, 32'd7,         32'd7, 5'd15, 32'd0, 1'b1);
    issue(6'b01_0_001, 32'd7,         32'd7, 5'd16, 32'd0, 1'b0);
    issue(6'b01_0_101, 32'hFFFF_FFFF, 32'd1, 5'd17, 32'd0, 1'b0);
    issue(6'b01_0_111, 32'hFFFF_FFFF, 32'd1, 5'd18, 32'd0, 1'b1);
    issue(6'b01_0_010, 32'd7,         32'd7, 5'd19, 32'd0, 1'b0);
    issue(6'b10_0_000, 32'd5,         32'd3, 5'd20, 32'd0, 1'b0);
    issue(6'b11_1_101, 32'd5,         32'd3, 5'd21, 32'd0, 1'b0);
    idle(3);

    // sra latency and in_ready during the operation
    issue(6'b00_1_101, 32'h8000_0000, 32'd4, 5'd22, 32'hF800_0000, 1'b0);
    lat = 1;
    rdy_seen = 0;
    @(negedge clk);
    while (!out_valid && lat < 64) begin
      if (in_ready) rdy_seen++;
      @(negedge clk);
      lat++;
    end
    check("sra_latency", 32'(lat), 32'(SRA4_LAT));
    check("sra_in_ready_low", 32'(rdy_seen), 0);
    idle(2);

    // Back-to-back full throughput
    pop_cyc.delete();
    for (int i = 0; i < 4; i++)
      issue(6'b00_0_000, 32'(i * 10), 32'd1, 5'(24 + i), 32'(i * 10 + 1), 1'b0);
    idle(3);
    check("b2b_count", 32'(pop_cyc.size()), 4);
    if (pop_cyc.size() == 4) check("b2b_span", 32'(pop_cyc[3] - pop_cyc[0]), 3);

    // Flush while holding an output with a new op offered
    @(posedge clk); #1 out_ready = 1'b0;
    issue(6'b00_0_000, 32'd1, 32'd1, 5'd28, 32'd2, 1'b0);
    @(negedge clk);
    check("pre_flush_valid", 32'(out_valid), 1);
    alu_control = 6'b00_0_000; operand_a = 32'd9; operand_b = 32'd9; rd_addr = 5'd29;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check("flush_valid", 32'(out_valid), 0);
    check("flush_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    check("flush_not_accepted", 32'(out_valid), 0);
    @(posedge clk); #1 out_ready = 1'b1;

`ifdef SERIAL_SHIFT_EN
    // Flush in the middle of a 20-bit serial shift
    issue(6'b00_0_001, 32'd1, 32'd20, 5'd30, 32'h0010_0000, 1'b0);
    idle(3);
    check("shift_busy_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    void'(sb.pop_back());
    rdy_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) rdy_seen++;
    end
    check("shift_flush_no_output", 32'(rdy_seen), 0);
    check("shift_flush_idle", 32'(in_ready), 1);
`endif

    // Asynchronous reset with an output pending, then normal recovery
    @(posedge clk); #1 out_ready = 1'b0;
    issue(6'b00_0_000, 32'd2, 32'd2, 5'd31, 32'd4, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_result", result, 0);
    check("arst_rd", 32'(out_rd_addr), 0);
    check("arst_branch", 32'(branch_taken), 0);
    sb.delete();
    out_ready = 1'b1;
    idle(2);
    rst_n = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 0);
    idle(1);
    check("release_next_in_ready", 32'(in_ready), 1);
    issue(6'b00_0_000, 32'd100, 32'd23, 5'd9, 32'd123, 1'b0);
    idle(5);
    check("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
